grs_driver: RTL and testbench
=============================

# grs_driver

Command sequencer that sits directly upstream of the gated RS latch stage and generates its `ENA`, `R` and `S` inputs. It accepts set/reset/toggle commands over a valid/ready handshake. For each command it produces a glitch-free pulse sequence: data setup with `ENA` low, then an `ENA` strobe, then a data hold with `ENA` low. `R` and `S` are never asserted together. With the verify option compiled in, it also reads the latch's `Q` back and flags any command that fails to take effect.

## Interface
- `SETUP_CYC`, 2: cycles that `R`/`S` are held with `ENA` low before the strobe (≥1).
- `PULSE_CYC`, 3: cycles `ENA` is high (≥1).
- `HOLD_CYC`, 2: cycles that `R`/`S` are held with `ENA` low after the strobe (≥1).
- `CHECK_CYC`, 8: maximum cycles to wait for `Q` to match; used only with `GRS_VERIFY_EN` (≥1).
- `CLK`, in, 1: rising-edge clock.
- `CLR_L`, in, 1: asynchronous, active-low reset.
- `CMD_VALID`, in, 1: command present.
- `CMD_OP`, in, 2: 00 = NOP, 01 = SET, 10 = RESET, 11 = TOGGLE.
- `CMD_READY`, out, 1: block can accept a command.
- `Q_IN`, in, 1: latch `Q`, asynchronous to `CLK`; passed through a 2-flop synchronizer.
- `ENA`, out, 1: latch enable.
- `R`, out, 1: latch reset.
- `S`, out, 1: latch set.
- `BUSY`, out, 1: high in every state except IDLE.
- `DONE`, out, 1: one-cycle completion pulse.
- `ERR`, out, 1: sticky verify failure; tied to 0 without `GRS_VERIFY_EN`.

## Operation
- FSM states: IDLE, SETUP, PULSE, HOLD, CHECK (macro only), FIN.
- All outputs except `CMD_READY` are registered.
- `CMD_READY` = (state == IDLE).
- A command is accepted on a rising edge where `CMD_VALID` and `CMD_READY` are both high.
- Operation resolution at acceptance:
  - SET drives `S`.
  - RESET drives `R`.
  - TOGGLE drives `R` if the synchronized Q is 1, otherwise `S`.
  - NOP goes straight to FIN with no `R`/`S`/`ENA` activity.
- Sequence:
  - SETUP: the selected `R` or `S` is 1, `ENA` = 0.
  - PULSE: the selected `R` or `S` is 1, `ENA` = 1.
  - HOLD: the selected `R` or `S` is 1, `ENA` = 0.
  - FIN: `R` = `S` = `ENA` = 0 and `DONE` = 1, then IDLE.
- `R` and `S` change only while `ENA` = 0. `ENA` never rises or falls in the same cycle that `R` or `S` changes.
- The phase down-counter is sized to clog2 of the largest parameter plus 1. It is loaded on every state entry and the state advances when it reaches 1.
- `CMD_OP` is ignored when no command is accepted. `CMD_VALID` held high during BUSY is not consumed.
- Reset (`CLR_L` = 0), at any time, including mid-sequence:
  - `ENA`, `R`, `S`, `DONE`, `BUSY`, `ERR` and both synchronizer flops go to 0 immediately.
  - State returns to IDLE.
  - `CMD_READY` is 1 once `CLR_L` is released.

## Timing
- Reference cycle 0 is the accepting edge.
- SET/RESET with default parameters:
  - `R`/`S` high in cycles 1–7.
  - `ENA` high in cycles 3–5.
  - `DONE` high in cycle 8 (FIN).
  - `CMD_READY` high in cycle 9.
- General case:
  - `ENA` rises in cycle 1+`SETUP_CYC`.
  - `DONE` is in cycle 1+`SETUP_CYC`+`PULSE_CYC`+`HOLD_CYC`.
- NOP: `DONE` in cycle 1; `CMD_READY` high in cycle 2.
- Back-to-back commands: the next command can be accepted on the first edge after FIN. This gives a minimum 1-cycle IDLE gap.
- `Q_IN` reaches the decision logic two edges after it changes at the pin.

## Configuration
- Macro: `GRS_VERIFY_EN`.
- Defined:
  - HOLD goes to CHECK with `R` = `S` = `ENA` = 0.
  - CHECK compares the synchronized Q against the expected value (1 for set, 0 for reset) every cycle.
  - On a match, CHECK goes to FIN on the next edge (at least 1 CHECK cycle).
  - After `CHECK_CYC` cycles without a match, CHECK goes to FIN and sets `ERR` in the same cycle as `DONE`.
  - `ERR` stays high until reset.
  - NOP skips CHECK.
- Undefined:
  - CHECK and its counter are absent; HOLD goes directly to FIN.
  - `ERR` is constant 0.
  - `Q_IN` is used only for TOGGLE resolution.

## Test plan
- Reset release, then SET (01) with defaults → `S` = 1 in cycles 1–7, `ENA` = 1 in cycles 3–5, `R` = 0 throughout, `DONE` in cycle 8, `CMD_READY` in cycle 9.
- Drive the real gated latch model from the outputs with `Q` looped back to `Q_IN`: RESET then TOGGLE twice → `Q` goes 0, 1, 0; TOGGLE selects `S`, then `R`.
- NOP while idle → `DONE` in cycle 1; `ENA`/`R`/`S` stay 0; `CMD_VALID` held high during BUSY is not accepted until `CMD_READY`.
- Pull `CLR_L` low during PULSE (cycle 4) → `ENA`/`R`/`S`/`BUSY` go to 0 without waiting for an edge; after release, `CMD_READY` = 1 and no `DONE` is produced.
- `GRS_VERIFY_EN` with `Q_IN` stuck at 0, SET issued → `DONE` and `ERR` assert together after 8 CHECK cycles; `ERR` stays high across a following successful RESET.
- Assertion across all tests: never `R` & `S`; `R`/`S` never change in the same cycle as an `ENA` edge.

Source files
------------

// File: rtl/grs_driver_if.sv
`default_nettype none
// ============================================================================
// Module   : grs_driver_if
// Purpose  : Command handshake and latch-side signals of the gated RS latch
//            sequencer. The slave modport is the sequencer itself; the
//            master modport is the commanding logic plus the latch Q pin.
// Revision : 1.0 - initial release
// ============================================================================
interface grs_driver_if;
  logic       CMD_VALID;
  logic [1:0] CMD_OP;
  logic       CMD_READY;
  logic       Q_IN;
  logic       ENA;
  logic       R;
  logic       S;
  logic       BUSY;
  logic       DONE;
  logic       ERR;

  modport master (
    output CMD_VALID, CMD_OP, Q_IN,
    input  CMD_READY, ENA, R, S, BUSY, DONE, ERR
  );

  modport slave (
    input  CMD_VALID, CMD_OP, Q_IN,
    output CMD_READY, ENA, R, S, BUSY, DONE, ERR
  );
endinterface
`default_nettype wire

// File: rtl/grs_driver.sv
`default_nettype none
// ============================================================================
// Module   : grs_driver
// Purpose  : Command sequencer for a gated RS latch. Each SET/RESET/TOGGLE
//            command becomes a setup / ENA strobe / hold pulse train on the
//            latch inputs, with R and S never active together and never
//            changing while ENA moves.
// Options  : GRS_VERIFY_EN - read the latch Q back after each command and
//            raise a sticky ERR when it fails to reach the expected value.
// Revision : 1.0 - initial release
// ============================================================================
module grs_driver #(
  parameter int SETUP_CYC = 2,
  parameter int PULSE_CYC = 3,
  parameter int HOLD_CYC  = 2,
  parameter int CHECK_CYC = 8
) (
  input wire          CLK,
  input wire          CLR_L,
  grs_driver_if.slave bus
);

  // Phase counter covers the longest phase of any kind.
  localparam int MAX_SP  = (SETUP_CYC > PULSE_CYC) ? SETUP_CYC : PULSE_CYC;
  localparam int MAX_HC  = (HOLD_CYC > CHECK_CYC) ? HOLD_CYC : CHECK_CYC;
  localparam int MAX_CYC = (MAX_SP > MAX_HC) ? MAX_SP : MAX_HC;
  localparam int CNT_W   = $clog2(MAX_CYC) + 1;

  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(SETUP_CYC);
  localparam logic [CNT_W-1:0] PULSE_LD = CNT_W'(PULSE_CYC);
  localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'(HOLD_CYC);
`ifdef GRS_VERIFY_EN
  localparam logic [CNT_W-1:0] CHECK_LD = CNT_W'(CHECK_CYC);
`endif

  localparam logic [1:0] OP_NOP    = 2'b00;
  localparam logic [1:0] OP_SET    = 2'b01;
  localparam logic [1:0] OP_RESET  = 2'b10;
  localparam logic [1:0] OP_TOGGLE = 2'b11;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_SETUP = 3'd1;
  localparam logic [2:0] ST_PULSE = 3'd2;
  localparam logic [2:0] ST_HOLD  = 3'd3;
`ifdef GRS_VERIFY_EN
  localparam logic [2:0] ST_CHECK = 3'd4;
`endif
  localparam logic [2:0] ST_FIN   = 3'd5;

  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  // 1 = the command drives S (and expects Q = 1), 0 = drives R (expects 0)
  logic             sel_s_q, sel_s_d;
  logic             q_meta_q, q_sync_q;
  logic             ena_q, ena_d;
  logic             r_q, r_d;
  logic             s_q, s_d;
  logic             done_q, done_d;
  logic             busy_q, busy_d;
`ifdef GRS_VERIFY_EN
  logic             err_q, err_d;
  logic             err_set;
`endif

  // Two-flop synchronizer for the asynchronous latch Q.
  always_ff @(posedge CLK or negedge CLR_L) begin
    if (!CLR_L) begin
      q_meta_q <= 1'b0;
      q_sync_q <= 1'b0;
    end else begin
      q_meta_q <= bus.Q_IN;
      q_sync_q <= q_meta_q;
    end
  end

  // State, phase counter and operation-select registers.
  always_ff @(posedge CLK or negedge CLR_L) begin
    if (!CLR_L) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      sel_s_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sel_s_q <= sel_s_d;
    end
  end

  // Next-state logic: accept commands in IDLE, count down each phase.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sel_s_d = sel_s_q;
`ifdef GRS_VERIFY_EN
    err_set = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (bus.CMD_VALID) begin
          case (bus.CMD_OP)
            OP_NOP: state_d = ST_FIN;
            OP_SET: begin
              state_d = ST_SETUP;
              cnt_d   = SETUP_LD;
              sel_s_d = 1'b1;
            end
            OP_RESET: begin
              state_d = ST_SETUP;
              cnt_d   = SETUP_LD;
              sel_s_d = 1'b0;
            end
            OP_TOGGLE: begin
              state_d = ST_SETUP;
              cnt_d   = SETUP_LD;
              sel_s_d = ~q_sync_q;
            end
          endcase
        end
      end
      ST_SETUP: begin
        if (cnt_q == CNT_ONE) begin
          state_d = ST_PULSE;
          cnt_d   = PULSE_LD;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      ST_PULSE: begin
        if (cnt_q == CNT_ONE) begin
          state_d = ST_HOLD;
          cnt_d   = HOLD_LD;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      ST_HOLD: begin
        if (cnt_q == CNT_ONE) begin
`ifdef GRS_VERIFY_EN
          state_d = ST_CHECK;
          cnt_d   = CHECK_LD;
`else
          state_d = ST_FIN;
`endif
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
`ifdef GRS_VERIFY_EN
      ST_CHECK: begin
        if (q_sync_q == sel_s_q) begin
          state_d = ST_FIN;
        end else if (cnt_q == CNT_ONE) begin
          state_d = ST_FIN;
          err_set = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
`endif
      ST_FIN:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Output decode from the next state so every output is a clean flop.
  always_comb begin
    ena_d  = 1'b0;
    r_d    = 1'b0;
    s_d    = 1'b0;
    done_d = 1'b0;
    busy_d = (state_d != ST_IDLE);
`ifdef GRS_VERIFY_EN
    err_d  = err_q | err_set;
`endif
    case (state_d)
      ST_SETUP, ST_HOLD: begin
        r_d = ~sel_s_d;
        s_d = sel_s_d;
      end
      ST_PULSE: begin
        r_d   = ~sel_s_d;
        s_d   = sel_s_d;
        ena_d = 1'b1;
      end
      ST_FIN:  done_d = 1'b1;
      default: ;
    endcase
  end

  // Output registers; reset clears the latch drive immediately.
  always_ff @(posedge CLK or negedge CLR_L) begin
    if (!CLR_L) begin
      ena_q  <= 1'b0;
      r_q    <= 1'b0;
      s_q    <= 1'b0;
      done_q <= 1'b0;
      busy_q <= 1'b0;
`ifdef GRS_VERIFY_EN
      err_q  <= 1'b0;
`endif
    end else begin
      ena_q  <= ena_d;
      r_q    <= r_d;
      s_q    <= s_d;
      done_q <= done_d;
      busy_q <= busy_d;
`ifdef GRS_VERIFY_EN
      err_q  <= err_d;
`endif
    end
  end

  assign bus.CMD_READY = (state_q == ST_IDLE);
  assign bus.ENA       = ena_q;
  assign bus.R         = r_q;
  assign bus.S         = s_q;
  assign bus.DONE      = done_q;
  assign bus.BUSY      = busy_q;
`ifdef GRS_VERIFY_EN
  assign bus.ERR       = err_q;
`else
  assign bus.ERR       = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_grs_driver.sv
`default_nettype none
// ============================================================================
// Module   : tb_grs_driver
// Purpose  : Directed bench for grs_driver driving a gated RS latch model
//            whose Q is looped back to Q_IN. Honours GRS_VERIFY_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_grs_driver;

`ifdef GRS_VERIFY_EN
  localparam int DONE_SEQ = 9;   // one CHECK cycle when Q already matches
`else
  localparam int DONE_SEQ = 8;
`endif

  logic CLK = 1'b0;
  logic CLR_L;
  logic latch_q = 1'b1;
  logic stuck_q0 = 1'b0;

  int total = 0;
  int bad   = 0;

  logic p_ena, p_r, p_s;
  bit   prev_ok = 1'b0;

  grs_driver_if bus ();

  grs_driver #(
    .SETUP_CYC(2),
    .PULSE_CYC(3),
    .HOLD_CYC (2),
    .CHECK_CYC(8)
  ) dut (
    .CLK  (CLK),
    .CLR_L(CLR_L),
    .bus  (bus)
  );

  always #5 CLK = ~CLK;

  // Gated RS latch: transparent while ENA is high.
  always @(bus.ENA or bus.R or bus.S) begin
    if (bus.ENA) begin
      if (bus.S)      latch_q = 1'b1;
      else if (bus.R) latch_q = 1'b0;
    end
  end

  assign bus.Q_IN = stuck_q0 ? 1'b0 : latch_q;

  task automatic chk(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Advance one cycle and check the latch-drive protocol.
  task automatic tick();
    @(posedge CLK);
    #1;
    chk("r_and_s_exclusive", bus.R & bus.S, 1'b0);
    if (prev_ok)
      chk("rs_change_on_ena_edge",
          ((bus.R != p_r) || (bus.S != p_s)) && (bus.ENA != p_ena), 1'b0);
    p_ena   = bus.ENA;
    p_r     = bus.R;
    p_s     = bus.S;
    prev_ok = CLR_L;
  endtask

  task automatic start(input logic [1:0] op);
    chk("ready_before_cmd", bus.CMD_READY, 1'b1);
    bus.CMD_VALID = 1'b1;
    bus.CMD_OP    = op;
    tick();
  endtask

  // Called in cycle 1 after the accepting edge; returns in cycle done_cyc+1.
  task automatic track(input string name, input bit seq, input bit es,
                       input bit er, input int done_cyc, input int err_rise,
                       input bit err0);
    for (int c = 1; c <= done_cyc + 1; c++) begin
      logic data, en, ex_err;
      data   = seq && (c <= 7);
      en     = seq && (c >= 3) && (c <= 5);
      ex_err = err0 || ((err_rise != 0) && (c >= err_rise));
      chk($sformatf("%s_S_c%0d", name, c), bus.S, es && data);
      chk($sformatf("%s_R_c%0d", name, c), bus.R, er && data);
      chk($sformatf("%s_ENA_c%0d", name, c), bus.ENA, en);
      chk($sformatf("%s_DONE_c%0d", name, c), bus.DONE, c == done_cyc);
      chk($sformatf("%s_BUSY_c%0d", name, c), bus.BUSY, c <= done_cyc);
      chk($sformatf("%s_READY_c%0d", name, c), bus.CMD_READY, c == done_cyc + 1);
      chk($sformatf("%s_ERR_c%0d", name, c), bus.ERR, ex_err);
      if (c <= done_cyc) tick();
    end
  endtask

  initial begin
    CLR_L         = 1'b0;
    bus.CMD_VALID = 1'b0;
    bus.CMD_OP    = 2'b00;
    p_ena = 1'b0; p_r = 1'b0; p_s = 1'b0;

    repeat (2) @(posedge CLK);
    #1;
    chk("rst_ENA", bus.ENA, 1'b0);
    chk("rst_R", bus.R, 1'b0);
    chk("rst_S", bus.S, 1'b0);
    chk("rst_DONE", bus.DONE, 1'b0);
    chk("rst_BUSY", bus.BUSY, 1'b0);
    chk("rst_ERR", bus.ERR, 1'b0);
    CLR_L = 1'b1;
    tick();
    chk("rel_READY", bus.CMD_READY, 1'b1);

    // SET with defaults, latch starts at 1
    start(2'b01);
    bus.CMD_VALID = 1'b0;
    bus.CMD_OP    = 2'b10;
    track("set", 1'b1, 1'b1, 1'b0, DONE_SEQ, 0, 1'b0);
    chk("latch_after_set", latch_q, 1'b1);

    // RESET then TOGGLE twice: Q 0, 1, 0
    start(2'b10);
    bus.CMD_VALID = 1'b0;
    track("reset", 1'b1, 1'b0, 1'b1, DONE_SEQ, 0, 1'b0);
    chk("latch_after_reset", latch_q, 1'b0);

    start(2'b11);
    bus.CMD_VALID = 1'b0;
    track("tog1", 1'b1, 1'b1, 1'b0, DONE_SEQ, 0, 1'b0);
    chk("latch_after_tog1", latch_q, 1'b1);

    start(2'b11);
    bus.CMD_VALID = 1'b0;
    track("tog2", 1'b1, 1'b0, 1'b1, DONE_SEQ, 0, 1'b0);
    chk("latch_after_tog2", latch_q, 1'b0);

    // NOP with CMD_VALID held high; the held SET waits for CMD_READY
    start(2'b00);
    bus.CMD_OP = 2'b01;
    track("nop", 1'b0, 1'b0, 1'b0, 1, 0, 1'b0);
    tick();
    bus.CMD_VALID = 1'b0;
    track("held_set", 1'b1, 1'b1, 1'b0, DONE_SEQ, 0, 1'b0);
    chk("latch_after_held_set", latch_q, 1'b1);

    // Reset asserted during PULSE (cycle 4)
    start(2'b10);
    bus.CMD_VALID = 1'b0;
    tick();
    tick();
    tick();
    chk("pre_rst_ENA", bus.ENA, 1'b1);
    chk("pre_rst_R", bus.R, 1'b1);
    #2;
    CLR_L   = 1'b0;
    prev_ok = 1'b0;
    #1;
    chk("midrst_ENA", bus.ENA, 1'b0);
    chk("midrst_R", bus.R, 1'b0);
    chk("midrst_S", bus.S, 1'b0);
    chk("midrst_BUSY", bus.BUSY, 1'b0);
    chk("midrst_DONE", bus.DONE, 1'b0);
    tick();
    CLR_L = 1'b1;
    chk("midrst_rel_READY", bus.CMD_READY, 1'b1);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk($sformatf("post_rst_DONE_%0d", i), bus.DONE, 1'b0);
      chk($sformatf("post_rst_BUSY_%0d", i), bus.BUSY, 1'b0);
    end

`ifdef GRS_VERIFY_EN
    // Q stuck low: SET times out after 8 CHECK cycles, ERR with DONE
    stuck_q0 = 1'b1;
    start(2'b01);
    bus.CMD_VALID = 1'b0;
    track("stuck_set", 1'b1, 1'b1, 1'b0, 16, 16, 1'b0);
    // Successful RESET afterwards leaves ERR high
    start(2'b10);
    bus.CMD_VALID = 1'b0;
    track("err_sticky", 1'b1, 1'b0, 1'b1, DONE_SEQ, 0, 1'b1);
    stuck_q0 = 1'b0;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
